// File: rtl/micron.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | micron : behavioural DRAM bank with a one-command-at-a-time front end.     |
// | Optional feature: define MICRON_PARITY_EN to enable the write parity check.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module micron #(
   parameter int ROW_AW     = 4,
   parameter int COL_AW     = 4,
   parameter int TEMP_LIMIT = 85
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  opcode,
   input  logic [9:0]  row,
   input  logic [9:0]  column,
   input  logic [31:0] data_in,
   input  logic [7:0]  temp,
   output logic [31:0] data_out,
   output logic [1:0]  error,
   output logic [2:0]  current_state_reg
);

   localparam int AW    = ROW_AW + COL_AW;
   localparam int DEPTH = 1 << AW;
   localparam logic [7:0] TEMP_LIMIT_C = 8'(TEMP_LIMIT);

   localparam logic [1:0] OP_NOP     = 2'b00;
   localparam logic [1:0] OP_READ    = 2'b01;
   localparam logic [1:0] OP_WRITE   = 2'b10;

   localparam logic [1:0] ERR_OK     = 2'b00;
   localparam logic [1:0] ERR_PARITY = 2'b01;
   localparam logic [1:0] ERR_TEMP   = 2'b10;
   localparam logic [1:0] ERR_ADDR   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WRITE   = 3'd1,
      S_READ    = 3'd2,
      S_REFRESH = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ROW_AW-1:0]   row_q, row_d;
   logic [COL_AW-1:0]   col_q, col_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [7:0]          temp_q, temp_d;
   logic                addr_bad_q, addr_bad_d;
   logic [31:0]         data_out_q, data_out_d;
   logic [1:0]          error_q, error_d;
   logic [ROW_AW-1:0]   rptr_q, rptr_d;
   logic [DEPTH-1:0]    valid_q, valid_d;
   logic [31:0]         mem_q [DEPTH];

   logic [AW-1:0]       addr;
   logic                parity_ok;
   logic                mem_we;
   logic [31:0]         rd_word;

   assign addr    = {row_q, col_q};
   assign rd_word = valid_q[addr] ? mem_q[addr] : 32'd0;

`ifdef MICRON_PARITY_EN
   // Even parity over the whole word, parity bit included.
   assign parity_ok = ~(^wdata_q);
`else
   assign parity_ok = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      wdata_d    = wdata_q;
      temp_d     = temp_q;
      addr_bad_d = addr_bad_q;
      data_out_d = data_out_q;
      error_d    = error_q;
      rptr_d     = rptr_q;
      valid_d    = valid_q;
      mem_we     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (opcode != OP_NOP) begin
               row_d      = row[ROW_AW-1:0];
               col_d      = column[COL_AW-1:0];
               wdata_d    = data_in;
               temp_d     = temp;
               addr_bad_d = ((row >> ROW_AW) != 10'd0) || ((column >> COL_AW) != 10'd0);
               case (opcode)
                  OP_READ:  state_d = S_READ;
                  OP_WRITE: state_d = S_WRITE;
                  default:  state_d = S_REFRESH;
               endcase
            end
         end
         S_WRITE: begin
            if (addr_bad_q) begin
               error_d = ERR_ADDR;
               state_d = S_ERROR;
            end else if (!parity_ok) begin
               error_d = ERR_PARITY;
               state_d = S_ERROR;
            end else begin
               mem_we        = 1'b1;
               valid_d[addr] = 1'b1;
               error_d       = ERR_OK;
               state_d       = S_IDLE;
            end
         end
         S_READ: begin
            if (addr_bad_q) begin
               error_d = ERR_ADDR;
               state_d = S_ERROR;
            end else begin
               data_out_d = rd_word;
               error_d    = ERR_OK;
               state_d    = S_IDLE;
            end
         end
         S_REFRESH: begin
            // The refresh pointer wraps naturally at its width.
            rptr_d  = rptr_q + 1'b1;
            error_d = (temp_q >= TEMP_LIMIT_C) ? ERR_TEMP : ERR_OK;
            state_d = S_IDLE;
         end
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         wdata_q    <= '0;
         temp_q     <= '0;
         addr_bad_q <= 1'b0;
         data_out_q <= '0;
         error_q    <= ERR_OK;
         rptr_q     <= '0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         wdata_q    <= wdata_d;
         temp_q     <= temp_d;
         addr_bad_q <= addr_bad_d;
         data_out_q <= data_out_d;
         error_q    <= error_d;
         rptr_q     <= rptr_d;
         valid_q    <= valid_d;
      end
   end

   // Storage array is deliberately not reset; the valid bits mask stale data.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[addr] <= wdata_q;
      end
   end

   assign data_out          = data_out_q;
   assign error             = error_q;
   assign current_state_reg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_micron.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for micron: directed vector table, reset-in-flight sequence,
// then randomized commands against a behavioural memory model.
module tb_micron;

   localparam int ROW_AW     = 4;
   localparam int COL_AW     = 4;
   localparam int TEMP_LIMIT = 85;
   localparam int DEPTH      = 1 << (ROW_AW + COL_AW);
`ifdef MICRON_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  opcode = 2'b00;
   logic [9:0]  row = '0;
   logic [9:0]  column = '0;
   logic [31:0] data_in = '0;
   logic [7:0]  temp = '0;
   logic [31:0] data_out;
   logic [1:0]  error;
   logic [2:0]  current_state_reg;

   micron #(.ROW_AW(ROW_AW), .COL_AW(COL_AW), .TEMP_LIMIT(TEMP_LIMIT)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .row(row), .column(column),
      .data_in(data_in), .temp(temp), .data_out(data_out), .error(error),
      .current_state_reg(current_state_reg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [31:0] m_mem   [DEPTH];
   bit          m_valid [DEPTH];
   logic [31:0] m_dout;
   logic [1:0]  m_err;

   typedef struct {
      logic [1:0]  op;
      logic [9:0]  r;
      logic [9:0]  c;
      logic [31:0] d;
      logic [7:0]  t;
      logic [2:0]  s1;
      logic [2:0]  s2;
      logic [1:0]  err;
      logic [31:0] dout;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_dout = '0;
      m_err  = 2'b00;
   endtask

   // Spec rules in plain arithmetic: returns expected state after the
   // sampling edge, state after the completion edge, error and data_out.
   task automatic model(input logic [1:0] op, input logic [9:0] r, input logic [9:0] c,
                        input logic [31:0] d, input logic [7:0] t,
                        output logic [2:0] e1, output logic [2:0] e2,
                        output logic [1:0] ee, output logic [31:0] ed);
      bit in_range;
      int a;
      in_range = (int'(r) < (1 << ROW_AW)) && (int'(c) < (1 << COL_AW));
      a  = int'(r) * (1 << COL_AW) + int'(c);
      e2 = 3'd0;
      if (op == 2'b01) begin
         e1 = 3'd2;
         if (!in_range) begin
            m_err = 2'b11; e2 = 3'd4;
         end else begin
            m_dout = m_valid[a] ? m_mem[a] : 32'd0;
            m_err  = 2'b00;
         end
      end else if (op == 2'b10) begin
         e1 = 3'd1;
         if (!in_range) begin
            m_err = 2'b11; e2 = 3'd4;
         end else if (PAR_EN && ($countones(d) % 2 == 1)) begin
            m_err = 2'b01; e2 = 3'd4;
         end else begin
            m_mem[a] = d; m_valid[a] = 1'b1; m_err = 2'b00;
         end
      end else begin
         e1    = 3'd3;
         m_err = (int'(t) >= TEMP_LIMIT) ? 2'b10 : 2'b00;
      end
      ee = m_err;
      ed = m_dout;
   endtask

   // Issues one command and scribbles random opcodes while the DUT is busy.
   task automatic issue(input logic [1:0] op, input logic [9:0] r, input logic [9:0] c,
                        input logic [31:0] d, input logic [7:0] t,
                        output logic [2:0] s1, output logic [2:0] s2, output logic [2:0] s3,
                        output logic [1:0] err, output logic [31:0] dout);
      @(negedge clk);
      opcode = op; row = r; column = c; data_in = d; temp = t;
      @(posedge clk); #1;
      s1      = current_state_reg;
      opcode  = 2'($urandom_range(1, 3));
      row     = 10'($urandom);
      column  = 10'($urandom);
      data_in = $urandom;
      temp    = 8'($urandom);
      @(posedge clk); #1;
      s2   = current_state_reg;
      err  = error;
      dout = data_out;
      if (s2 == 3'd4) begin
         @(posedge clk); #1;
      end
      s3     = current_state_reg;
      opcode = 2'b00;
   endtask

   initial begin
      logic [2:0]  s1, s2, s3, e1, e2;
      logic [1:0]  err, ee;
      logic [31:0] dout, ed;
      logic [9:0]  rr, cc;
      logic [31:0] dd;
      logic [1:0]  op;

      tbl[0]  = '{2'b10, 10'd5,  10'd10, 32'h99973111, 8'd0,   3'd1, 3'd0, 2'b00, 32'h0};
      tbl[1]  = '{2'b01, 10'd5,  10'd10, 32'h0,        8'd0,   3'd2, 3'd0, 2'b00, 32'h99973111};
      tbl[2]  = '{2'b11, 10'd0,  10'd0,  32'h0,        8'd30,  3'd3, 3'd0, 2'b00, 32'h99973111};
      tbl[3]  = '{2'b11, 10'd0,  10'd0,  32'h0,        8'd90,  3'd3, 3'd0, 2'b10, 32'h99973111};
      tbl[4]  = '{2'b11, 10'd0,  10'd0,  32'h0,        8'd85,  3'd3, 3'd0, 2'b10, 32'h99973111};
      tbl[5]  = '{2'b11, 10'd0,  10'd0,  32'h0,        8'd84,  3'd3, 3'd0, 2'b00, 32'h99973111};
      tbl[6]  = '{2'b10, 10'd7,  10'd8,  32'h89973111, 8'd0,   3'd1, PAR_EN ? 3'd4 : 3'd0,
                  PAR_EN ? 2'b01 : 2'b00, 32'h99973111};
      tbl[7]  = '{2'b01, 10'd7,  10'd8,  32'h0,        8'd0,   3'd2, 3'd0, 2'b00,
                  PAR_EN ? 32'h0 : 32'h89973111};
      tbl[8]  = '{2'b01, 10'd64, 10'd0,  32'h0,        8'd0,   3'd2, 3'd4, 2'b11,
                  PAR_EN ? 32'h0 : 32'h89973111};
      tbl[9]  = '{2'b10, 10'd0,  10'd16, 32'h0,        8'd0,   3'd1, 3'd4, 2'b11,
                  PAR_EN ? 32'h0 : 32'h89973111};
      tbl[10] = '{2'b11, 10'd1023, 10'd1023, 32'h0,    8'd10,  3'd3, 3'd0, 2'b00,
                  PAR_EN ? 32'h0 : 32'h89973111};
      tbl[11] = '{2'b01, 10'd0,  10'd0,  32'h0,        8'd0,   3'd2, 3'd0, 2'b00, 32'h0};
      tbl[12] = '{2'b10, 10'd15, 10'd15, 32'hFFFFFFFF, 8'd0,   3'd1, 3'd0, 2'b00, 32'h0};
      tbl[13] = '{2'b01, 10'd15, 10'd15, 32'h0,        8'd0,   3'd2, 3'd0, 2'b00, 32'hFFFFFFFF};

      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_state", 32'(current_state_reg), 32'd0);
      chk("reset_error", 32'(error), 32'd0);
      chk("reset_dout",  data_out, 32'd0);

      for (int i = 0; i < NV; i++) begin
         model(tbl[i].op, tbl[i].r, tbl[i].c, tbl[i].d, tbl[i].t, e1, e2, ee, ed);
         issue(tbl[i].op, tbl[i].r, tbl[i].c, tbl[i].d, tbl[i].t, s1, s2, s3, err, dout);
         chk($sformatf("vec%0d_state1", i), 32'(s1), 32'(tbl[i].s1));
         chk($sformatf("vec%0d_state2", i), 32'(s2), 32'(tbl[i].s2));
         chk($sformatf("vec%0d_state3", i), 32'(s3), 32'd0);
         chk($sformatf("vec%0d_error", i),  32'(err), 32'(tbl[i].err));
         chk($sformatf("vec%0d_dout", i),   dout, tbl[i].dout);
      end

      // Reset asserted while a write of 5/10 sits in the WRITE state.
      @(negedge clk);
      opcode = 2'b10; row = 10'd5; column = 10'd10; data_in = 32'h00000003;
      @(posedge clk); #1;
      chk("rstmid_in_write", 32'(current_state_reg), 32'd1);
      opcode = 2'b00;
      #2 rst = 1'b1;
      #1;
      chk("rstmid_state", 32'(current_state_reg), 32'd0);
      chk("rstmid_error", 32'(error), 32'd0);
      chk("rstmid_dout",  data_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      model(2'b01, 10'd5, 10'd10, 32'h0, 8'd0, e1, e2, ee, ed);
      issue(2'b01, 10'd5, 10'd10, 32'h0, 8'd0, s1, s2, s3, err, dout);
      chk("rst_read_state2", 32'(s2), 32'd0);
      chk("rst_read_error",  32'(err), 32'd0);
      chk("rst_read_dout",   dout, 32'd0);

      for (int n = 0; n < 300; n++) begin
         op = 2'($urandom_range(1, 3));
         rr = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 3));
         cc = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 3));
         dd = $urandom;
         if ($urandom_range(0, 1) == 1) dd[0] = dd[0] ^ (^dd);
         model(op, rr, cc, dd, 8'($urandom_range(70, 100)), e1, e2, ee, ed);
         issue(op, rr, cc, dd, temp_pick(ee, op), s1, s2, s3, err, dout);
         chk($sformatf("rnd%0d_state1", n), 32'(s1), 32'(e1));
         chk($sformatf("rnd%0d_state2", n), 32'(s2), 32'(e2));
         chk($sformatf("rnd%0d_state3", n), 32'(s3), 32'd0);
         chk($sformatf("rnd%0d_error", n),  32'(err), 32'(ee));
         chk($sformatf("rnd%0d_dout", n),   dout, ed);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Chooses a temperature consistent with the refresh result the model
   // already committed to, landing on either side of the limit boundary.
   function automatic logic [7:0] temp_pick(input logic [1:0] ee, input logic [1:0] op);
      if (op != 2'b11) return 8'($urandom);
      if (ee == 2'b10) return 8'(TEMP_LIMIT + int'($urandom_range(0, 3)));
      return 8'(TEMP_LIMIT - 1 - int'($urandom_range(0, 3)));
   endfunction

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
